// File: rtl/brq_dmem_pkg.sv
// Shared definitions for the data-memory bridge: FSM states, funct3 size codes
// and the byte-lane helpers used on the store and request side.
package brq_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } dmem_state_e;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // Byte-lane strobes; only the width bits of the size code matter here.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Unsupported size codes are reported exactly like a misaligned access.
    function automatic logic access_ok(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_B, SIZE_BU: ok = 1'b1;
            SIZE_H, SIZE_HU: ok = ~addr_lo[0];
            SIZE_W:          ok = (addr_lo == 2'b00);
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] wdata_align(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/brq_load_align.sv
// Load-side lane select: picks the addressed byte/half of the bus word and
// sign- or zero-extends it according to the funct3 size code.
module brq_load_align
    import brq_dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = word[8*gi +: 8];
    end

    assign byte_sel = lanes[addr_lo];
    assign half_sel = {lanes[{addr_lo[1], 1'b1}], lanes[{addr_lo[1], 1'b0}]};

    always_comb begin
        data = word;
        case (size)
            SIZE_B:  data = {{24{byte_sel[7]}}, byte_sel};
            SIZE_BU: data = {24'h000000, byte_sel};
            SIZE_H:  data = {{16{half_sel[15]}}, half_sel};
            SIZE_HU: data = {16'h0000, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/brq_dmem_bridge.sv
// Bridges the core's single-cycle load/store request onto a req/gnt/rvalid
// data-memory bus, stalling the core until completion or timeout.
module brq_dmem_bridge
    import brq_dmem_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 15,
    parameter int TimeoutCycles = 255
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] core_addr,
    input  logic [DataWidth-1:0] core_wdata,
    input  logic                 core_read_en,
    input  logic                 core_write_en,
    input  logic [2:0]           core_byte_en,
    output logic [DataWidth-1:0] core_rdata,
    output logic                 core_stall,
    output logic                 core_misalign,
    output logic                 core_err,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [AddrWidth-3:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [DataWidth-1:0] bus_wdata,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [DataWidth-1:0] bus_rdata
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    dmem_state_e          state_reg, state_next;
    logic [CntWidth-1:0]  cnt_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [DataWidth-1:0] wdata_reg;
    logic [DataWidth-1:0] rdata_reg;
    logic [2:0]           size_reg;
    logic                 we_reg;
    logic                 err_reg;

    logic                 req_any;
    logic                 capture;
    logic                 load_done;
    logic                 timeout;
    logic [DataWidth-1:0] load_data;

    brq_load_align u_load_align (
        .size    (size_reg),
        .addr_lo (addr_reg[1:0]),
        .word    (bus_rdata),
        .data    (load_data)
    );

    always_comb begin
        state_next    = state_reg;
        capture       = 1'b0;
        load_done     = 1'b0;
        timeout       = 1'b0;
        core_stall    = 1'b0;
        core_misalign = 1'b0;
        req_any       = core_read_en | core_write_en;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    if (access_ok(core_byte_en, core_addr[1:0])) begin
                        capture    = 1'b1;
                        core_stall = 1'b1;
                        state_next = REQ;
                    end else begin
                        core_misalign = 1'b1;
                    end
                end
            end
            REQ: begin
                core_stall = 1'b1;
                if (bus_gnt) begin
                    state_next = we_reg ? RESP : WAIT;
                end else if (cnt_reg == CntLast) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT: begin
                core_stall = 1'b1;
                if (bus_rvalid) begin
                    load_done  = 1'b1;
                    state_next = RESP;
                end else if (cnt_reg == CntLast) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write wins when both enables are set; the bus fields only carry the
    // captured request while it is actually being offered.
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= '0;
            we_reg    <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (state_reg == REQ || state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (capture) begin
                addr_reg  <= core_addr;
                wdata_reg <= core_wdata;
                size_reg  <= core_byte_en;
                we_reg    <= core_write_en;
            end
            if (load_done) begin
                rdata_reg <= load_data;
            end else if (timeout) begin
                rdata_reg <= '0;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus_req    = (state_reg == REQ);
    assign bus_we     = bus_req & we_reg;
    assign bus_addr   = bus_req ? addr_reg[AddrWidth-1:2] : '0;
    assign bus_be     = bus_req ? be_gen(size_reg, addr_reg[1:0]) : 4'b0000;
    assign bus_wdata  = bus_we ? wdata_align(size_reg, wdata_reg) : '0;
    assign core_rdata = rdata_reg;
    assign core_err   = err_reg;

endmodule

// File: tb/tb_brq_dmem_bridge.sv
// Randomised bench for brq_dmem_bridge: a transaction-level model predicts every
// cycle's outputs; directed accesses pin literal results.
module tb_brq_dmem_bridge;

    localparam int AW = 15;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic          core_read_en;
    logic          core_write_en;
    logic [2:0]    core_byte_en;
    logic [31:0]   core_rdata;
    logic          core_stall;
    logic          core_misalign;
    logic          core_err;
    logic          bus_req;
    logic          bus_we;
    logic [AW-3:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;

    always #5 clk = ~clk;

    brq_dmem_bridge #(
        .DataWidth     (32),
        .AddrWidth     (AW),
        .TimeoutCycles (TO)
    ) dut (
        .brq_clk       (clk),
        .brq_rst       (rst_n),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_read_en  (core_read_en),
        .core_write_en (core_write_en),
        .core_byte_en  (core_byte_en),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .core_misalign (core_misalign),
        .core_err      (core_err),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata)
    );

    // Expected outputs for the current cycle (written by the driver only).
    string         tag = "reset";
    bit            e_chk = 1'b0, e_all = 1'b0;
    bit            e_stall, e_mis, e_req, e_we, e_chkwd, e_err;
    logic [AW-3:0] e_addr;
    logic [3:0]    e_be;
    logic [31:0]   e_wdata, e_rdata;

    // Transaction-level model state.
    logic [31:0]   m_rdata;
    bit            m_err;
    int            txn_n = 0;

    // Literal pins handed to the compare process.
    string         p_name [8];
    logic [31:0]   p_act  [8];
    logic [31:0]   p_exp  [8];
    int            p_cnt = 0, p_seq = 0;

    // Owned by the compare process.
    int            checks = 0, failures = 0, p_done = 0;
    int            stall_run = 0, req_run = 0, mis_run = 0;
    int            last_stall_run = 0, last_req_run = 0, last_mis_run = 0;
    logic [3:0]    obs_be = '0;
    logic [31:0]   obs_wdata = '0;
    logic [AW-3:0] obs_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s] t=%0t got=%h want=%h", name, tag, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (e_chk) begin
            check("core_stall", 32'(core_stall), 32'(e_stall));
            check("core_misalign", 32'(core_misalign), 32'(e_mis));
            check("core_rdata", core_rdata, e_rdata);
            check("core_err", 32'(core_err), 32'(e_err));
            check("bus_req", 32'(bus_req), 32'(e_req));
            if (e_req || e_all) begin
                check("bus_we", 32'(bus_we), 32'(e_we));
                check("bus_addr", 32'(bus_addr), 32'(e_addr));
                check("bus_be", 32'(bus_be), 32'(e_be));
                if (e_chkwd || e_all) check("bus_wdata", bus_wdata, e_wdata);
            end
        end
        if (p_seq != p_done) begin
            for (int i = 0; i < p_cnt; i++) check(p_name[i], p_act[i], p_exp[i]);
            p_done = p_seq;
        end
        if (core_stall) stall_run++;
        else begin
            if (stall_run != 0) last_stall_run = stall_run;
            stall_run = 0;
        end
        if (bus_req) begin
            req_run++;
            obs_be = bus_be; obs_wdata = bus_wdata; obs_addr = bus_addr;
        end else begin
            if (req_run != 0) last_req_run = req_run;
            req_run = 0;
        end
        if (core_misalign) mis_run++;
        else begin
            if (mis_run != 0) last_mis_run = mis_run;
            mis_run = 0;
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input int nb, input int off);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_lanes(input int nb, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input int off, input logic [31:0] word);
        longint v;
        int     bits;
        bits = 8 * nbytes(sz);
        v = longint'(word) >> (8 * off);
        v = v & ((64'sd1 <<< bits) - 1);
        if (sz[2] == 1'b0 && bits < 32 && v[bits-1]) v = v - (64'sd1 <<< bits);
        return v[31:0];
    endfunction

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit stall, input bit mis, input bit req);
        e_chk = 1'b1; e_all = 1'b0;
        e_stall = stall; e_mis = mis; e_req = req;
        e_rdata = m_rdata; e_err = m_err;
    endtask

    task automatic expect_all_zero();
        e_chk = 1'b1; e_all = 1'b1;
        e_stall = 0; e_mis = 0; e_req = 0; e_we = 0; e_chkwd = 0; e_err = 0;
        e_addr = '0; e_be = '0; e_wdata = '0; e_rdata = '0;
    endtask

    task automatic core_idle();
        core_read_en = 0; core_write_en = 0; core_addr = '0; core_wdata = '0; core_byte_en = '0;
    endtask

    task automatic core_junk();
        core_addr = AW'($urandom); core_wdata = $urandom; core_byte_en = 3'($urandom);
        core_read_en = 1'($urandom); core_write_en = 1'($urandom);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(); core_idle(); bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
            tag = "idle"; set_exp(0, 0, 0);
        end
    endtask

    // Idle cycle, then wait until its outputs have been compared, ready for pins.
    task automatic idle_pin();
        idle_n(1);
        @(negedge clk);
        #1;
        p_cnt = 0;
    endtask

    task automatic pin(input string n, input logic [31:0] act, input logic [31:0] exp);
        p_name[p_cnt] = n; p_act[p_cnt] = act; p_exp[p_cnt] = exp;
        p_cnt++;
    endtask

    task automatic pins_done();
        p_seq++;
    endtask

    // One core access; g = REQ cycles without grant, r = WAIT cycles without rvalid.
    task automatic run_txn(input bit wr, input bit rd, input logic [2:0] sz, input logic [AW-1:0] a,
                           input logic [31:0] wd, input int g, input int r, input logic [31:0] word);
        bit is_wr, ok, tmo;
        int nb, off, k;
        is_wr = wr;
        nb    = nbytes(sz);
        off   = int'(a[1:0]);
        ok    = 1'b0;
        if (nb != 0) ok = ((int'(a) % nb) == 0);
        txn_n++;
        tag = $sformatf("txn%0d", txn_n);
        $display("TXN %0d %s sz=%b addr=%h wdata=%h gnt_dly=%0d rv_dly=%0d aligned=%0d",
                 txn_n, is_wr ? "ST" : "LD", sz, a, wd, g, r, ok);
        step();
        core_addr = a; core_wdata = wd; core_byte_en = sz; core_read_en = rd; core_write_en = wr;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
        set_exp(ok, !ok, 0);
        if (!ok) return;
        e_we = is_wr; e_addr = a[AW-1:2]; e_be = m_be(nb, off); e_wdata = m_lanes(nb, wd); e_chkwd = is_wr;
        tmo = 1'b0;
        for (k = 1; k <= TO; k++) begin
            step(); core_junk(); bus_gnt = (k == g + 1); bus_rdata = $urandom;
            set_exp(1, 0, 1);
            if (k == g + 1) break;
            if (k == TO) tmo = 1'b1;
        end
        if (!is_wr && !tmo) begin
            for (k = 1; k <= TO; k++) begin
                step(); core_junk(); bus_gnt = 0; bus_rvalid = (k == r + 1);
                bus_rdata = (k == r + 1) ? word : $urandom;
                set_exp(1, 0, 0);
                if (k == r + 1) break;
                if (k == TO) tmo = 1'b1;
            end
        end
        if (tmo) begin
            m_err = 1'b1; m_rdata = '0;
        end else if (!is_wr) begin
            m_rdata = m_load(sz, off, word);
        end
        step(); core_junk(); bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
        set_exp(0, 0, 0);
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] a);
        tag = "reset_mid_read";
        step();
        core_idle(); core_addr = a; core_byte_en = 3'b010; core_read_en = 1;
        set_exp(1, 0, 0);
        e_we = 0; e_addr = a[AW-1:2]; e_be = 4'b1111; e_chkwd = 0;
        step(); core_idle(); bus_gnt = 1; set_exp(1, 0, 1);
        step(); bus_gnt = 0; set_exp(1, 0, 0);
        step(); rst_n = 0; m_rdata = '0; m_err = 1'b0; expect_all_zero();
        step(); rst_n = 1; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D; set_exp(0, 0, 0);
        step(); bus_rvalid = 0; set_exp(0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; core_idle(); bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
        m_rdata = '0; m_err = 1'b0;
        repeat (3) begin step(); expect_all_zero(); end
        step(); rst_n = 1; tag = "idle"; set_exp(0, 0, 0);

        run_txn(0, 1, 3'b010, 15'h0010, 32'h0, 0, 0, 32'hDEADBEEF);
        idle_pin();
        pin("lw_rdata", core_rdata, 32'hDEADBEEF); pin("lw_be", 32'(obs_be), 32'h0000000F);
        pin("lw_addr", 32'(obs_addr), 32'h00000004); pin("lw_stall_cycles", 32'(last_stall_run), 32'd3);
        pins_done();

        run_txn(0, 1, 3'b000, 15'h0013, 32'h0, 0, 0, 32'h80FF0000);
        idle_pin();
        pin("lb_be", 32'(obs_be), 32'h00000008); pin("lb_rdata", core_rdata, 32'hFFFFFF80);
        pins_done();

        run_txn(0, 1, 3'b100, 15'h0013, 32'h0, 0, 0, 32'h80FF0000);
        idle_pin();
        pin("lbu_rdata", core_rdata, 32'h00000080);
        pins_done();

        run_txn(1, 0, 3'b001, 15'h0006, 32'h1234ABCD, 4, 0, 32'h0);
        idle_pin();
        pin("sh_req_cycles", 32'(last_req_run), 32'd5); pin("sh_be", 32'(obs_be), 32'h0000000C);
        pin("sh_wdata", obs_wdata, 32'hABCDABCD); pin("sh_stall_cycles", 32'(last_stall_run), 32'd6);
        pin("sh_rdata_kept", core_rdata, 32'h00000080);
        pins_done();

        run_txn(0, 1, 3'b001, 15'h0001, 32'h0, 0, 0, 32'h0);
        idle_pin();
        pin("lh_mis_cycles", 32'(last_mis_run), 32'd1); pin("lh_rdata_kept", core_rdata, 32'h00000080);
        pins_done();

        run_txn(0, 1, 3'b010, 15'h0020, 32'h0, 0, 99, 32'h0);
        idle_pin();
        pin("tmo_err", 32'(core_err), 32'd1); pin("tmo_rdata", core_rdata, 32'h0);
        pin("tmo_stall_cycles", 32'(last_stall_run), 32'd10);
        pins_done();

        run_txn(0, 1, 3'b010, 15'h0024, 32'h0, 1, 2, 32'h0BADF00D);
        idle_pin();
        pin("post_tmo_rdata", core_rdata, 32'h0BADF00D); pin("post_tmo_err", 32'(core_err), 32'd1);
        pins_done();

        run_txn(1, 0, 3'b010, 15'h0040, 32'h55AA55AA, 99, 0, 32'h0);
        idle_pin();
        pin("req_tmo_cycles", 32'(last_req_run), 32'd8);
        pins_done();

        for (int n = 0; n < 150; n++) begin
            bit wr, rd;
            int g, r;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            g  = ($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(0, TO - 2));
            r  = ($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(0, TO - 2));
            run_txn(wr, rd, 3'($urandom_range(0, 7)), AW'($urandom), $urandom, g, r, $urandom);
            idle_n(int'($urandom_range(0, 2)));
        end

        run_txn(0, 1, 3'b010, 15'h0100, 32'h0, 0, 0, 32'h12345678);
        reset_mid_read(15'h0200);
        idle_pin();
        pin("rst_rdata", core_rdata, 32'h0); pin("rst_err", 32'(core_err), 32'd0);
        pins_done();

        run_txn(0, 1, 3'b101, 15'h0302, 32'h0, 0, 0, 32'h8001FFFF);
        idle_pin();
        pin("lhu_rdata", core_rdata, 32'h00008001);
        pins_done();

        idle_n(2);
        e_chk = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brq_dmem_bridge.md
Name: brq_dmem_bridge

Overview:
- Sits directly downstream of the core's load/store stage, on the data-memory side.
- Accepts the core's single-cycle data-memory request (address, read/write enable, byte-enable code, store data) and turns it into a req/gnt/rvalid handshake toward a variable-latency data memory or bus.
- Aligns store data into byte lanes and extracts and sign- or zero-extends load data.
- Stalls the core until each transaction completes and aborts hung transactions with a timeout.

Parameters:
- DataWidth, 32, data bus width (fixed at 32; byte-lane logic assumes 4 lanes)
- AddrWidth, 15, core byte-address width
- TimeoutCycles, 255, maximum cycles in REQ or WAIT before abort; counter width is $clog2(TimeoutCycles+1)

Ports:
- brq_clk  input  1  clock
- brq_rst  input  1  reset, asynchronous, active-low
- core_addr  input  AddrWidth  byte address
- core_wdata  input  32  store data, right-aligned
- core_read_en  input  1  load request
- core_write_en  input  1  store request
- core_byte_en  input  3  funct3 size code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- core_rdata  output  32  extended load result
- core_stall  output  1  hold the core pipeline
- core_misalign  output  1  one-cycle pulse, misaligned access rejected
- core_err  output  1  sticky timeout flag, cleared only by reset
- bus_req  output  1  request valid
- bus_we  output  1  1 = write
- bus_addr  output  AddrWidth-2  word address
- bus_be  output  4  byte-lane strobes
- bus_wdata  output  32  lane-aligned store data
- bus_gnt  input  1  request accepted
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read word

Behaviour:
- Clock and reset: single clock brq_clk. brq_rst is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; timeout counter 0; captured request registers 0.
- FSM states IDLE, REQ, WAIT, RESP.
- IDLE:
  - read_en or write_en, aligned → capture addr, wdata, size and we; go to REQ. core_stall = 1 combinationally in this same cycle.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) → no bus activity, core_misalign = 1 for one cycle, core_stall = 0, core_rdata unchanged, stay in IDLE.
  - read_en and write_en both high → treated as a write.
  - Unsupported size codes (011, 11x) → treated as misaligned.
- REQ:
  - bus_req = 1 with stable bus_we, bus_addr, bus_be and bus_wdata until bus_gnt.
  - On gnt: a write goes to RESP; a read goes to WAIT.
- WAIT: on bus_rvalid, latch extended data into core_rdata and go to RESP. rvalid in the same cycle as gnt is not supported; the bus guarantees at least one cycle between them.
- RESP: core_stall = 0 for exactly this cycle, then return to IDLE. A new core request is not sampled in RESP; the core presents the next access in the following cycle.
- core_stall = 1 in REQ and WAIT, and in IDLE when a valid aligned request is present.
- Minimum latency: read = 3 cycles of stall (request cycle + REQ with immediate gnt + WAIT with rvalid next), then RESP. Write = 2 cycles of stall.
- Lane alignment:
  - bus_be: byte → 0001 << addr[1:0]; half → 0011 << addr[1:0]; word → 1111.
  - bus_wdata: the low byte or half of core_wdata is replicated into all lanes.
  - For reads, bus_be reflects the access size (informational).
- Load extraction:
  - Select lane by addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears on any state change.
  - Reaching TimeoutCycles → go to RESP, set core_err, core_rdata = 0, drop bus_req.
- Reset mid-transaction: immediate return to IDLE; bus_req drops asynchronously; any late gnt or rvalid arriving in IDLE is ignored.
- core_rdata holds its value between loads; only completed reads or timeouts update it.

Decomposition:
- Package brq_dmem_pkg:
  - enum dmem_state_e {IDLE, REQ, WAIT, RESP}
  - localparams for the funct3 size codes
  - function be_gen(size, addr_lo)
- Sub-module brq_load_align: combinational lane select and sign/zero extension. It is instantiated once and unit-tested separately.

Test Plan:
- LW at 0x0010, gnt in the first REQ cycle, rvalid one cycle later with 0xDEADBEEF → bus_addr=0x004, bus_be=1111, stall high 3 cycles, core_rdata=0xDEADBEEF in RESP.
- LB at 0x0013 with bus_rdata=0x80FF_0000 → bus_be=1000, core_rdata=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH at 0x0006 with wdata=0x1234ABCD, gnt delayed 4 cycles → bus_req held 5 cycles with stable bus_be=1100 and bus_wdata=0xABCDABCD; stall released in RESP; no rvalid is awaited.
- LH at 0x0001 → core_misalign pulses one cycle, bus_req stays 0, core_stall 0, core_rdata unchanged.
- Read with gnt but no rvalid, TimeoutCycles=8 → abort after 8 cycles in WAIT, core_err=1 sticky, core_rdata=0, FSM returns to IDLE; a subsequent LW completes normally.
- Reset asserted in WAIT → all outputs 0 immediately; a late rvalid after reset release is ignored and core_rdata stays 0.
